// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control stage in front of the 8:1 ALU result mux.
// Accepts one opcode at a time over valid/ready, drives the mux select, and
// sequences MULT as LOAD + WIDTH shift-add STEP cycles + write-back.
// Optional build macro ALU_SEQ_ABORT_EN adds the abort input and aborted pulse.
// CNT_W must satisfy 2**CNT_W > WIDTH so WIDTH-1 fits in the step counter.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    output logic [2:0] sel,
    output logic       mult_load,
    output logic       mult_step,
    output logic       res_we,
    output logic       done,
`ifdef ALU_SEQ_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_LOAD = 3'd2,
        ST_STEP = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    localparam logic [2:0]       OP_MULT   = 3'b111;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_sel;
    logic             w_idle;
    logic             w_accept;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = req_valid && w_idle;

`ifdef ALU_SEQ_ABORT_EN
    logic w_abort_hit;
    logic r_aborted;

    // Abort only matters while the multiplier is being driven.
    assign w_abort_hit = abort && ((r_state == ST_LOAD) || (r_state == ST_STEP));

    // One-cycle pulse in the cycle following the abort edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
        end
    end

    assign aborted = r_aborted;
`endif

    // State, step counter and latched opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_sel <= req_op;
            end
        end
    end

    // Next-state and counter update; MULT leaves STEP on the edge where the counter is 0.
    always_comb begin
        // NOTE: hold-current defaults first so no path leaves a target unassigned (no latch).
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (req_op == OP_MULT) ? ST_LOAD : ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_IDLE;
            ST_LOAD: begin
                w_state_next = ST_STEP;
                w_cnt_next   = CNT_START;
            end
            ST_STEP: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_WB;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_WB:   w_state_next = ST_IDLE;
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
`ifdef ALU_SEQ_ABORT_EN
        if (w_abort_hit) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end
`endif
    end

    // Outputs are pure decodes of registered state, so no input reaches an output combinationally.
    assign req_ready = w_idle;
    assign busy      = !w_idle;
    assign sel       = r_sel;
    assign mult_load = (r_state == ST_LOAD);
    assign mult_step = (r_state == ST_STEP);
    assign res_we    = (r_state == ST_EXEC) || (r_state == ST_WB);
    assign done      = res_we;

endmodule
